// File: rtl/i2c_pkg.sv
// ---------------------------------------------------------------------------
// i2c_pkg
// Shared constants and types for the I2C line monitor. The slave controller
// bench also uses it.
//   I2C_FILTER_LEN_DEFAULT  default glitch-filter length (samples)
//   I2C_TIMEOUT_DEFAULT     default SCL-low timeout (clk cycles)
//   I2C_TO_CNT_W            width of the timeout counter
//   I2C_LINE_IDLE           idle (released) level of an open-drain I2C line
//   bus_state_e             bus tracking state
//   filter_last()           last count value before a filtered line commits
// ---------------------------------------------------------------------------
package i2c_pkg;

    localparam int              I2C_FILTER_LEN_DEFAULT = 3;
    localparam int              I2C_TO_CNT_W           = 16;
    localparam logic [15:0]     I2C_TIMEOUT_DEFAULT    = 16'd50000;
    localparam logic            I2C_LINE_IDLE          = 1'b1;

    typedef enum logic {
        BUS_IDLE = 1'b0,
        BUS_BUSY = 1'b1
    } bus_state_e;

    // The filter count starts at 0 on the first differing sample. The line
    // therefore flips on the sample where the count already equals len-1.
    function automatic logic [3:0] filter_last(input int len);
        return 4'(len - 1);
    endfunction

endpackage

// File: rtl/i2c_line_monitor_if.sv
// ---------------------------------------------------------------------------
// i2c_line_monitor_if
// Raw pad inputs and filtered/decoded outputs of the I2C line monitor.
//   master : the environment side; it drives the raw lines and timeout_en
//            and observes the monitor outputs.
//   slave  : the monitor itself.
// Signals:
//   scl_raw, sda_raw   pad inputs, asynchronous to clk
//   timeout_en         enables the SCL-stuck timeout
//   scl, sda           filtered lines
//   scl_rise, scl_fall one-cycle filtered SCL edge pulses
//   start_detected     one-cycle pulse on START or repeated START
//   stop_detected      one-cycle pulse on STOP
//   bus_busy           high from START until STOP
//   scl_stuck          SCL held low too long while busy
// ---------------------------------------------------------------------------
interface i2c_line_monitor_if;

    logic scl_raw;
    logic sda_raw;
    logic timeout_en;
    logic scl;
    logic sda;
    logic scl_rise;
    logic scl_fall;
    logic start_detected;
    logic stop_detected;
    logic bus_busy;
    logic scl_stuck;

    modport master (
        output scl_raw, sda_raw, timeout_en,
        input  scl, sda, scl_rise, scl_fall,
               start_detected, stop_detected, bus_busy, scl_stuck
    );

    modport slave (
        input  scl_raw, sda_raw, timeout_en,
        output scl, sda, scl_rise, scl_fall,
               start_detected, stop_detected, bus_busy, scl_stuck
    );

endinterface

// File: rtl/i2c_glitch_filter.sv
// ---------------------------------------------------------------------------
// i2c_glitch_filter
// Two-flop synchronizer followed by a run-length glitch filter for one I2C
// line. The filtered line flips only after FILTER_LEN consecutive
// synchronized samples that differ from it. Any sample equal to the current
// value restarts the run. The latency from a raw edge to the filtered edge
// is 2+FILTER_LEN cycles.
// Ports:
//   clk, rst   clock; asynchronous active-high reset
//   i_raw      raw pad input
//   o_line     filtered line (resets to idle-high)
//   o_rise     one-cycle pulse, high in the cycle o_line goes 0->1
//   o_fall     one-cycle pulse, high in the cycle o_line goes 1->0
// ---------------------------------------------------------------------------
module i2c_glitch_filter
    import i2c_pkg::*;
#(
    parameter int FILTER_LEN = I2C_FILTER_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_line,
    output logic o_rise,
    output logic o_fall
);

    localparam logic [3:0] CNT_LAST = filter_last(FILTER_LEN);

    logic [1:0] r_sync;
    logic       r_line;
    logic [3:0] r_cnt;
    logic       r_rise;
    logic       r_fall;

    logic       w_sample;
    logic       w_differs;
    logic       w_commit;

    assign w_sample  = r_sync[1];
    assign w_differs = (w_sample != r_line);
    assign w_commit  = w_differs && (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= {2{I2C_LINE_IDLE}};
            r_line <= I2C_LINE_IDLE;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            // The edge pulses are registered together with the line, so
            // they are high exactly in the cycle the line is new.
            r_rise <= w_commit &  w_sample;
            r_fall <= w_commit & ~w_sample;
            if (w_commit) begin
                r_line <= w_sample;
                r_cnt  <= '0;
            end else if (w_differs) begin
                r_cnt  <= r_cnt + 4'd1;
            end else begin
                r_cnt  <= '0;
            end
        end
    end

    assign o_line = r_line;
    assign o_rise = r_rise;
    assign o_fall = r_fall;

endmodule

// File: rtl/i2c_line_monitor.sv
// ---------------------------------------------------------------------------
// i2c_line_monitor
// Filters the SCL/SDA pads and decodes START/STOP conditions. It tracks bus
// occupancy and flags a bus whose SCL is held low too long during a transfer.
// Parameters:
//   FILTER_LEN      samples needed to change a filtered line (1..15)
//   TIMEOUT_CYCLES  cycles of SCL low while busy before scl_stuck
// Ports:
//   clk, rst  clock; asynchronous active-high reset
//   bus       i2c_line_monitor_if.slave (raw lines in, decoded status out)
// ---------------------------------------------------------------------------
module i2c_line_monitor
    import i2c_pkg::*;
#(
    parameter int                      FILTER_LEN     = I2C_FILTER_LEN_DEFAULT,
    parameter logic [I2C_TO_CNT_W-1:0] TIMEOUT_CYCLES = I2C_TIMEOUT_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    i2c_line_monitor_if.slave    bus
);

    // Index 0 is SCL and index 1 is SDA.
    logic [1:0] w_raw;
    logic [1:0] w_line;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_raw = {bus.sda_raw, bus.scl_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            i2c_glitch_filter #(
                .FILTER_LEN (FILTER_LEN)
            ) u_filt (
                .clk    (clk),
                .rst    (rst),
                .i_raw  (w_raw[gi]),
                .o_line (w_line[gi]),
                .o_rise (w_rise[gi]),
                .o_fall (w_fall[gi])
            );
        end
    endgenerate

    // ---------------- START / STOP decode ----------------
    logic r_scl_prev;
    logic w_scl_steady_high;
    logic w_start;
    logic w_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scl_prev <= I2C_LINE_IDLE;
        end else begin
            r_scl_prev <= w_line[0];
        end
    end

    // SCL must be high now and in the previous cycle. If SCL changes in the
    // same cycle as SDA, this condition fails, so a simultaneous change
    // never decodes as START or STOP.
    assign w_scl_steady_high = w_line[0] & r_scl_prev;
    assign w_start           = w_fall[1] & w_scl_steady_high;
    assign w_stop            = w_rise[1] & w_scl_steady_high;

    // ---------------- bus occupancy FSM ----------------
    bus_state_e r_state;
    bus_state_e w_state_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= BUS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A repeated START while busy keeps the FSM in BUSY.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            BUS_IDLE: if (w_start) w_state_next = BUS_BUSY;
            BUS_BUSY: if (w_stop)  w_state_next = BUS_IDLE;
            default:               w_state_next = BUS_IDLE;
        endcase
    end

    logic w_busy;
    assign w_busy = (r_state == BUS_BUSY);

    // ---------------- SCL-low timeout ----------------
    logic [I2C_TO_CNT_W-1:0] r_to_cnt;
    logic                    w_to_run;
    logic                    w_to_hit;

    assign w_to_run = bus.timeout_en & w_busy & ~w_line[0];
    assign w_to_hit = (r_to_cnt == TIMEOUT_CYCLES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
        end else if (!w_to_run) begin
            r_to_cnt <= '0;
        end else if (!w_to_hit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Gating with w_to_run drops the flag in the first cycle SCL is high,
    // even though the counter clears only on the following edge. STOP needs
    // SCL high, so it is covered by the same gating.
    assign bus.scl_stuck      = w_to_hit & w_to_run;

    assign bus.scl            = w_line[0];
    assign bus.sda            = w_line[1];
    assign bus.scl_rise       = w_rise[0];
    assign bus.scl_fall       = w_fall[0];
    assign bus.start_detected = w_start;
    assign bus.stop_detected  = w_stop;
    assign bus.bus_busy       = w_busy;

endmodule

// File: doc/i2c_line_monitor.md
I2C_LINE_MONITOR -- requirements
Module: i2c_line_monitor

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with the ports named clk and rst.
REQ-002 Parameter FILTER_LEN, default 3, SHALL set the number of consecutive identical synchronized samples needed to change a filtered line (legal range 1..15).
REQ-003 Parameter TIMEOUT_CYCLES, default 16'd50000, SHALL set the number of clk cycles of continuous filtered SCL low, while busy, before a stuck-bus flag is raised.
REQ-004 clk  input  1  system clock; SCL and SDA are sampled on its rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 scl_raw  input  1  SCL pad input, asynchronous to clk.
REQ-007 sda_raw  input  1  SDA pad input, asynchronous to clk.
REQ-008 timeout_en  input  1  enables the SCL-stuck timeout counter.
REQ-009 scl  output  1  filtered SCL, fed to the slave controller and the shifter.
REQ-010 sda  output  1  filtered SDA, fed to the slave controller as sda_in.
REQ-011 scl_rise  output  1  one-cycle pulse on a filtered SCL 0->1 transition.
REQ-012 scl_fall  output  1  one-cycle pulse on a filtered SCL 1->0 transition.
REQ-013 start_detected  output  1  one-cycle pulse on START or repeated START.
REQ-014 stop_detected  output  1  one-cycle pulse on STOP.
REQ-015 bus_busy  output  1  level; high from START until STOP.
REQ-016 scl_stuck  output  1  level; SCL-low timeout flag.

Function
REQ-017 Each raw line SHALL pass through a 2-flop synchronizer preset to 1.
REQ-018 Each filtered line SHALL change only after FILTER_LEN consecutive synchronized samples that differ from its current value.
- Any intervening sample equal to the current value SHALL clear the filter count.
REQ-019 Latency from a raw edge to the filtered edge SHALL be exactly 2+FILTER_LEN clk cycles.
REQ-020 scl_rise and scl_fall SHALL assert in the same cycle the filtered scl changes, for one cycle only.
REQ-021 START SHALL be reported when filtered sda goes 1->0 while filtered scl is 1 in both the current and the previous cycle.
REQ-022 STOP SHALL be reported when filtered sda goes 0->1 while filtered scl is 1 in both the current and the previous cycle.
REQ-023 When filtered scl and filtered sda change in the same cycle, no START or STOP SHALL be reported.
REQ-024 A START while bus_busy=1 (repeated START) SHALL pulse start_detected, and bus_busy SHALL stay 1.
REQ-025 bus_busy SHALL set in the cycle after a start_detected pulse and clear in the cycle after a stop_detected pulse.
REQ-026 The timeout counter SHALL behave as follows:
- It increments each cycle while timeout_en=1, bus_busy=1 and filtered scl=0.
- It clears whenever any of those conditions is false.
- It saturates at TIMEOUT_CYCLES.
REQ-027 scl_stuck SHALL assert in the cycle the counter reaches TIMEOUT_CYCLES and deassert on the first cycle filtered scl=1, on STOP, or on rst.
REQ-028 scl_stuck SHALL NOT alter bus_busy or suppress the START/STOP pulses.
REQ-029 At most one of start_detected and stop_detected SHALL be high in any cycle.

Reset
REQ-030 On rst assertion, the following SHALL take these values immediately, independent of clk:
- synchronizer flops, scl and sda: 1;
- scl_rise, scl_fall, start_detected, stop_detected, bus_busy, scl_stuck: 0;
- filter and timeout counters: 0.
REQ-031 Reset asserted mid-transfer SHALL abort tracking; no STOP pulse SHALL be generated for the aborted transfer.
REQ-032 After rst deassertion with both raw lines low, the filtered lines SHALL fall after 2+FILTER_LEN cycles, and no START SHALL be reported.

Structure
REQ-033 Shared package i2c_pkg SHALL hold the following, for reuse by the slave controller bench:
- the FILTER_LEN and TIMEOUT_CYCLES defaults;
- the timeout counter width constant (16);
- the line-idle constant (1'b1).
REQ-034 The synchronizer plus filter SHALL be one sub-module, i2c_glitch_filter, instantiated once for SCL and once for SDA.

Verification
REQ-035 The bench SHALL cover the following directed scenarios with FILTER_LEN=3:
- Glitch rejection: scl_raw high, sda_raw pulses low for 2 cycles -> sda stays 1, no start_detected.
- START: scl_raw high, sda_raw falls and holds -> filtered sda falls 5 cycles later, start_detected pulses that cycle, bus_busy=1 the next cycle.
- Repeated START then STOP: second START while busy -> second start_detected pulse with bus_busy still 1; sda_raw rises with scl high -> stop_detected pulse, bus_busy=0 the next cycle.
- Simultaneous change: scl_raw and sda_raw toggle in the same clk edge -> scl_fall pulses, no start_detected or stop_detected.
- Timeout with TIMEOUT_CYCLES=20, timeout_en=1, busy: hold scl_raw low -> scl_stuck=1 exactly 20 cycles after the filtered scl fall; release scl_raw -> scl_stuck=0 when filtered scl rises.
- Reset mid-transfer: rst asserted while bus_busy=1 -> all outputs take their REQ-030 values asynchronously, and no stop_detected pulse occurs.
